// File: rtl/io_responder.sv
// Memory-mapped I/O responder: LED register, synchronised switches, down-counting timer with sticky expiry flag.
// Latency: reads are combinational (zero cycles); writes take effect on the sampling edge; switches appear after 2 edges.
// Backpressure: none; every IORead/IOWrite strobe is serviced in the cycle it is presented.
module io_responder #(
  parameter int LED_WIDTH   = 24,
  parameter int SW_WIDTH    = 24,
  parameter int TIMER_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 IORead,
  input  logic                 IOWrite,
  input  logic [9:0]           addr,
  input  logic [31:0]          write_data,
  input  logic [SW_WIDTH-1:0]  switch_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [31:0]          read_data,
  output logic                 timer_irq
);

  localparam logic [9:0] A_TLOAD  = 10'h020;
  localparam logic [9:0] A_TCTRL  = 10'h024;
  localparam logic [9:0] A_TSTAT  = 10'h028;
  localparam logic [9:0] A_TCOUNT = 10'h02C;
  localparam logic [9:0] A_LED    = 10'h060;
  localparam logic [9:0] A_SW     = 10'h070;

  logic [SW_WIDTH-1:0]    sw_meta;
  logic [SW_WIDTH-1:0]    sw_sync;
  logic [TIMER_WIDTH-1:0] tload;
  logic [TIMER_WIDTH-1:0] count;
  logic                   tmr_en;
  logic                   tmr_auto;
  logic                   expired;

  logic wr_led;
  logic wr_tload;
  logic wr_tctrl;
  logic rd_tstat;
  logic fire;

  assign wr_led   = IOWrite && (addr == A_LED);
  assign wr_tload = IOWrite && (addr == A_TLOAD);
  assign wr_tctrl = IOWrite && (addr == A_TCTRL);
  assign rd_tstat = IORead  && (addr == A_TSTAT);

  // Expiry happens when running at zero; a TLOAD write that edge replaces the count instead.
  assign fire = tmr_en && (count == '0) && !wr_tload;

  assign timer_irq = expired;

  // LED output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_out <= '0;
    end else if (wr_led) begin
      led_out <= write_data[LED_WIDTH-1:0];
    end
  end

  // Two-flop synchroniser for the asynchronous board switches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
    end
  end

  // Timer: IDLE/RUN is held in tmr_en; counter, reload and control registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tload    <= '0;
      count    <= '0;
      tmr_en   <= 1'b0;
      tmr_auto <= 1'b0;
    end else begin
      if (wr_tload) begin
        tload <= write_data[TIMER_WIDTH-1:0];
        count <= write_data[TIMER_WIDTH-1:0];
      end else if (tmr_en) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else if (tmr_auto) begin
          count <= tload;
        end
      end
      if (wr_tctrl) begin
        tmr_en   <= write_data[0];
        tmr_auto <= write_data[1];
      end else if (fire && !tmr_auto) begin
        tmr_en <= 1'b0;
      end
    end
  end

  // Sticky expiry flag: a same-edge expiry beats a clearing TSTAT read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      expired <= 1'b0;
    end else if (fire) begin
      expired <= 1'b1;
    end else if (rd_tstat) begin
      expired <= 1'b0;
    end
  end

  // Combinational read mux, zero when not reading or unmapped
  always_comb begin
    read_data = '0;
    if (IORead) begin
      case (addr)
        A_LED:    read_data = 32'(led_out);
        A_SW:     read_data = 32'(sw_sync);
        A_TLOAD:  read_data = 32'(tload);
        A_TCTRL:  read_data = {30'd0, tmr_auto, tmr_en};
        A_TSTAT:  read_data = {31'd0, expired};
        A_TCOUNT: read_data = 32'(count);
        default:  read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed register/timer scenarios followed by a random access phase.
// Every step checks read_data before the edge and led_out/timer_irq after it against a reference model.
// Expected values come from constants or the model below; nothing is read back from the DUT.
module tb_io_responder;

  logic        clock;
  logic        reset;
  logic        IORead;
  logic        IOWrite;
  logic [9:0]  addr;
  logic [31:0] write_data;
  logic [23:0] switch_in;
  logic [23:0] led_out;
  logic [31:0] read_data;
  logic        timer_irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_rd;

  // Reference state, in architectural terms
  logic [23:0] m_led, m_s1, m_s2;
  logic [31:0] m_tload, m_count;
  logic        m_en, m_auto, m_flag;

  io_responder #(.LED_WIDTH(24), .SW_WIDTH(24), .TIMER_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .IORead(IORead), .IOWrite(IOWrite),
    .addr(addr), .write_data(write_data), .switch_in(switch_in),
    .led_out(led_out), .read_data(read_data), .timer_irq(timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_s1 = '0; m_s2 = '0;
    m_tload = '0; m_count = '0;
    m_en = 1'b0; m_auto = 1'b0; m_flag = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic rd, input logic [9:0] a);
    if (!rd) return 32'd0;
    case (a)
      10'h060: return {8'd0, m_led};
      10'h070: return {8'd0, m_s2};
      10'h020: return m_tload;
      10'h024: return {30'd0, m_auto, m_en};
      10'h028: return {31'd0, m_flag};
      10'h02C: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic rd, input logic wr, input logic [9:0] a,
                            input logic [31:0] wd, input logic [23:0] sw);
    logic load_now, fire;
    load_now = wr && (a == 10'h020);
    fire = m_en && (m_count == 0) && !load_now;
    if (load_now) begin
      m_tload = wd;
      m_count = wd;
    end else if (m_en) begin
      if (m_count != 0) m_count = m_count - 1;
      else if (m_auto)  m_count = m_tload;
    end
    if (wr && a == 10'h024) begin
      m_en = wd[0];
      m_auto = wd[1];
    end else if (fire && !m_auto) begin
      m_en = 1'b0;
    end
    if (fire) m_flag = 1'b1;
    else if (rd && a == 10'h028) m_flag = 1'b0;
    if (wr && a == 10'h060) m_led = wd[23:0];
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  // One bus cycle: present inputs, check the combinational read, clock, check registered outputs
  task automatic step(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] wd);
    IORead = rd; IOWrite = wr; addr = a; write_data = wd;
    #1;
    last_rd = read_data;
    chk("read_data", read_data, model_read(rd, a));
    @(posedge clock);
    model_edge(rd, wr, a, wd, switch_in);
    #1;
    chk("led_out", {8'd0, led_out}, {8'd0, m_led});
    chk("timer_irq", {31'd0, timer_irq}, {31'd0, m_flag});
    IORead = 1'b0; IOWrite = 1'b0;
  endtask

  task automatic rd_const(input string tag, input logic [9:0] a, input logic [31:0] exp);
    step(1'b1, 1'b0, a, 32'd0);
    chk(tag, last_rd, exp);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'($urandom), $urandom);
  endtask

  initial begin
    logic [9:0] amap [7];
    amap = '{10'h060, 10'h070, 10'h020, 10'h024, 10'h028, 10'h02C, 10'h3FC};

    // Reset held low with random activity on the inputs
    reset = 1'b0;
    IORead = 1'b1; IOWrite = 1'b1; addr = 10'h060; write_data = $urandom;
    switch_in = 24'($urandom);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      IOWrite = 1'($urandom); addr = amap[$urandom_range(0, 6)];
      write_data = $urandom; switch_in = 24'($urandom);
    end
    chk("rst_led", {8'd0, led_out}, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    IORead = 1'b0; IOWrite = 1'b0;
    reset = 1'b1;

    rd_const("rst_rd_led",    10'h060, 32'd0);
    rd_const("rst_rd_tload",  10'h020, 32'd0);
    rd_const("rst_rd_tctrl",  10'h024, 32'd0);
    rd_const("rst_rd_tstat",  10'h028, 32'd0);
    rd_const("rst_rd_tcount", 10'h02C, 32'd0);

    // LED register
    wr(10'h060, 32'h00A5A5A5);
    chk("led_write", {8'd0, led_out}, 32'h00A5A5A5);
    rd_const("led_read", 10'h060, 32'h00A5A5A5);
    wr(10'h070, 32'hFFFFFFFF);
    chk("led_after_sw_write", {8'd0, led_out}, 32'h00A5A5A5);

    // Switch synchroniser latency
    switch_in = 24'h000000;
    idle(3);
    switch_in = 24'h123456;
    rd_const("sw_edge0", 10'h070, 32'd0);
    rd_const("sw_edge1", 10'h070, 32'd0);
    rd_const("sw_edge2", 10'h070, 32'h00123456);
    step(1'b0, 1'b0, 10'h070, 32'd0);
    chk("sw_no_read", last_rd, 32'd0);

    // One-shot timer
    step(1'b1, 1'b0, 10'h028, 32'd0);
    wr(10'h020, 32'd5);
    wr(10'h024, 32'd1);
    for (int k = 5; k >= 0; k--) rd_const("oneshot_count", 10'h02C, 32'(k));
    chk("oneshot_irq", {31'd0, timer_irq}, 32'd1);
    rd_const("oneshot_en_clear", 10'h024, 32'd0);
    rd_const("oneshot_tstat1", 10'h028, 32'd1);
    rd_const("oneshot_tstat0", 10'h028, 32'd0);

    // Auto-reload: period 4, clear colliding with expiry
    wr(10'h020, 32'd3);
    wr(10'h024, 32'd3);
    idle(3);
    chk("auto_pre_irq", {31'd0, timer_irq}, 32'd0);
    rd_const("auto_tstat_a", 10'h028, 32'd0);
    chk("auto_irq_set", {31'd0, timer_irq}, 32'd1);
    idle(3);
    rd_const("auto_tstat_b", 10'h028, 32'd1);
    chk("auto_set_wins", {31'd0, timer_irq}, 32'd1);
    rd_const("auto_tstat_c", 10'h028, 32'd1);
    chk("auto_cleared", {31'd0, timer_irq}, 32'd0);
    wr(10'h024, 32'd0);

    // Reset in the middle of a count
    wr(10'h020, 32'd100);
    wr(10'h024, 32'd1);
    idle(50);
    rd_const("mid_count", 10'h02C, 32'd50);
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_led", {8'd0, led_out}, 32'd0);
    chk("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
    #1;
    reset = 1'b1;
    rd_const("mid_tcount", 10'h02C, 32'd0);
    rd_const("mid_tctrl", 10'h024, 32'd0);
    idle(200);
    chk("mid_no_expiry", {31'd0, timer_irq}, 32'd0);
    rd_const("mid_tcount_end", 10'h02C, 32'd0);

    // Random accesses across the map
    for (int i = 0; i < 400; i++) begin
      logic [9:0]  a;
      logic [31:0] d;
      logic        do_wr;
      if ($urandom_range(0, 7) == 0) switch_in = 24'($urandom);
      a = ($urandom_range(0, 5) == 0) ? 10'($urandom) : amap[$urandom_range(0, 6)];
      do_wr = ($urandom_range(0, 2) == 0);
      d = $urandom;
      if (a == 10'h020) d = 32'($urandom_range(0, 12));
      if (a == 10'h024 && $urandom_range(0, 1) == 1) d = d | 32'd1;
      step(!do_wr, do_wr, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
